// File: rtl/tour_pkg.sv
// Shared definitions for the knight tour move sequencer: state encoding,
// command opcodes, heading bytes, response bytes and leg command builders.
package tour_pkg;

  // Sequencer state encoding
  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'd0;
  localparam state_t ST_LOAD   = 4'd1;
  localparam state_t ST_VERT   = 4'd2;
  localparam state_t ST_WAIT_V = 4'd3;
  localparam state_t ST_HORZ   = 4'd4;
  localparam state_t ST_WAIT_H = 4'd5;
  localparam state_t ST_PAUSED = 4'd6;
  localparam state_t ST_ABORT  = 4'd7;
  localparam state_t ST_DONE   = 4'd8;

  // Heading bytes understood by the command processor
  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  // Command opcodes (upper nibble of a command word)
  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_MOVE_FF = 4'b0011;
  localparam logic [3:0] OP_PAUSE   = 4'b0000;
  localparam logic [3:0] OP_ABORT   = 4'b1111;

  // Response bytes returned to the host
  localparam logic [7:0] RESP_MV   = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_ABT  = 8'hEE;

  // Vertical leg: plain move, north for positive dy, squares = |dy|
  function automatic logic [15:0] vert_cmd(input logic signed [2:0] dy);
    logic [2:0] raw;
    logic [2:0] mag;
    logic [7:0] hdg;
    raw = dy;
    mag = raw[2] ? (3'd0 - raw) : raw;
    hdg = raw[2] ? HDG_SOUTH : HDG_NORTH;
    return {OP_MOVE, hdg, 1'b0, mag};
  endfunction

  // Horizontal leg: move with fanfare, east for positive dx, squares = |dx|
  function automatic logic [15:0] horz_cmd(input logic signed [2:0] dx);
    logic [2:0] raw;
    logic [2:0] mag;
    logic [7:0] hdg;
    raw = dx;
    mag = raw[2] ? (3'd0 - raw) : raw;
    hdg = raw[2] ? HDG_WEST : HDG_EAST;
    return {OP_MOVE_FF, hdg, 1'b0, mag};
  endfunction

endpackage

// File: rtl/knight_move_decode.sv
// Combinational decode of a one-hot knight move into signed (dx, dy) offsets.
module knight_move_decode
  import tour_pkg::*;
(
  input  logic              [7:0] move,
  output logic signed       [2:0] dx,
  output logic signed       [2:0] dy,
  output logic                    valid
);

  // Map each one-hot move bit to its offset; anything not exactly one-hot is invalid
  always_comb begin
    dx    = 3'sd0;
    dy    = 3'sd0;
    valid = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
    case (move)
      8'h01: begin dx =  3'sd1; dy =  3'sd2; end
      8'h02: begin dx = -3'sd1; dy =  3'sd2; end
      8'h04: begin dx = -3'sd2; dy =  3'sd1; end
      8'h08: begin dx = -3'sd2; dy = -3'sd1; end
      8'h10: begin dx = -3'sd1; dy = -3'sd2; end
      8'h20: begin dx =  3'sd1; dy = -3'sd2; end
      8'h40: begin dx =  3'sd2; dy = -3'sd1; end
      8'h80: begin dx =  3'sd2; dy =  3'sd1; end
      default: begin dx = 3'sd0; dy = 3'sd0; end
    endcase
  end

endmodule

// File: rtl/tour_move_sequencer.sv
// Tour command sequencer: passes host commands through when idle or paused,
// otherwise walks the solver's move list issuing a vertical then a horizontal
// leg per knight move, with pause/resume and abort support.
module tour_move_sequencer
  import tour_pkg::*;
#(
  parameter int BOARD_DIM = 5,
  parameter int CMD_W     = 16,
  parameter int IDX_W     = $clog2(BOARD_DIM*BOARD_DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [CMD_W-1:0] cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             paused
);

  localparam int NUM_MV = BOARD_DIM*BOARD_DIM - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MV - 1);

  state_t             state;
  logic [CMD_W-1:0]   cmd_q;
  logic               cmd_rdy_q;
  logic signed [2:0]  dx_q;
  logic               pause_pend;
  logic               resume_horz;

  logic signed [2:0]  dec_dx;
  logic signed [2:0]  dec_dy;
  logic               dec_valid;
  logic               pause_req;
  logic               abort_req;
  logic               pause_now;

  knight_move_decode u_decode (
    .move  (move),
    .dx    (dec_dx),
    .dy    (dec_dy),
    .valid (dec_valid)
  );

  // Host pause/abort requests; an abort already in progress is not re-armed
  always_comb begin
    pause_req = cmd_rdy_UART && (cmd_UART[15:12] == OP_PAUSE) &&
                (state != ST_IDLE) && (state != ST_PAUSED);
    abort_req = (cmd_UART[15:12] == OP_ABORT) &&
                (state != ST_IDLE) && (state != ST_ABORT);
    pause_now = pause_pend || pause_req;
  end

  // Main tour sequencing: leg handshakes, move index, responses, pause and abort
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mv_indx     <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      resp        <= RESP_MV;
      dx_q        <= 3'sd0;
      pause_pend  <= 1'b0;
      resume_horz <= 1'b0;
    end else if (abort_req) begin
      state      <= ST_ABORT;
      cmd_rdy_q  <= 1'b0;
      resp       <= RESP_ABT;
      mv_indx    <= '0;
      pause_pend <= 1'b0;
    end else begin
      if (pause_req) begin
        pause_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          pause_pend <= 1'b0;
          if (start_tour) begin
            state   <= ST_LOAD;
            mv_indx <= '0;
            resp    <= RESP_MV;
          end
        end
        ST_LOAD: begin
          if (dec_valid) begin
            dx_q      <= dec_dx;
            cmd_q     <= CMD_W'(vert_cmd(dec_dy));
            cmd_rdy_q <= 1'b1;
            state     <= ST_VERT;
          end else begin
            state      <= ST_ABORT;
            cmd_rdy_q  <= 1'b0;
            resp       <= RESP_ABT;
            mv_indx    <= '0;
            pause_pend <= 1'b0;
          end
        end
        ST_VERT: begin
          if (clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state     <= ST_WAIT_V;
          end
        end
        ST_WAIT_V: begin
          if (send_resp) begin
            if (pause_now) begin
              state       <= ST_PAUSED;
              resume_horz <= 1'b1;
              pause_pend  <= 1'b0;
            end else begin
              cmd_q     <= CMD_W'(horz_cmd(dx_q));
              cmd_rdy_q <= 1'b1;
              state     <= ST_HORZ;
            end
          end
        end
        ST_HORZ: begin
          if (clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state     <= ST_WAIT_H;
          end
        end
        ST_WAIT_H: begin
          if (send_resp) begin
            pause_pend <= 1'b0;
            if (mv_indx == LAST_IDX) begin
              resp  <= RESP_DONE;
              state <= ST_DONE;
            end else begin
              resp    <= RESP_MV;
              mv_indx <= mv_indx + 1'b1;
              if (pause_now) begin
                state       <= ST_PAUSED;
                resume_horz <= 1'b0;
              end else begin
                state <= ST_LOAD;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (start_tour) begin
            if (resume_horz) begin
              cmd_q     <= CMD_W'(horz_cmd(dx_q));
              cmd_rdy_q <= 1'b1;
              state     <= ST_HORZ;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Host commands pass straight through while idle or paused
  always_comb begin
    cmd     = cmd_q;
    cmd_rdy = cmd_rdy_q;
    if ((state == ST_IDLE) || (state == ST_PAUSED)) begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
    end
  end

  assign tour_busy = (state != ST_IDLE);
  assign paused    = (state == ST_PAUSED);

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Self-checking bench for tour_move_sequencer: 5x5 and 6x6 instances share the
// host/handshake inputs; random solver lists are checked against a move-table model.
module tb_tour_move_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start5, start6, cmd_rdy_UART, clr_cmd_rdy, send_resp;
  logic [15:0] cmd_UART;
  logic [7:0]  move5, move6;
  logic [4:0]  idx5;
  logic [5:0]  idx6;
  logic [15:0] cmd5, cmd6;
  logic        rdy5, rdy6, busy5, busy6, paused5, paused6;
  logic [7:0]  resp5, resp6;

  logic [7:0]  sol5 [0:31];
  logic [7:0]  sol6 [0:63];
  logic        force_en;
  logic [7:0]  force_mv;
  logic        use6;

  int n_checks = 0;
  int n_fail   = 0;

  int DX [0:7] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY [0:7] = '{2, 2, 1, -1, -2, -2, -1, 1};

  assign move5 = force_en ? force_mv : sol5[idx5];
  assign move6 = sol6[idx6];

  logic [15:0] c_cmd;
  logic        c_rdy, c_busy;
  logic [7:0]  c_resp;
  logic [5:0]  c_idx;
  assign c_cmd  = use6 ? cmd6  : cmd5;
  assign c_rdy  = use6 ? rdy6  : rdy5;
  assign c_busy = use6 ? busy6 : busy5;
  assign c_resp = use6 ? resp6 : resp5;
  assign c_idx  = use6 ? idx6  : {1'b0, idx5};

  tour_move_sequencer #(.BOARD_DIM(5)) dut5 (
    .clk(clk), .rst(rst), .start_tour(start5), .move(move5), .mv_indx(idx5),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cmd(cmd5), .cmd_rdy(rdy5), .resp(resp5),
    .tour_busy(busy5), .paused(paused5)
  );

  tour_move_sequencer #(.BOARD_DIM(6)) dut6 (
    .clk(clk), .rst(rst), .start_tour(start6), .move(move6), .mv_indx(idx6),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .cmd(cmd6), .cmd_rdy(rdy6), .resp(resp6),
    .tour_busy(busy6), .paused(paused6)
  );

  // Reference model: knight move table -> leg command words
  function automatic int mv_bit(input logic [7:0] m);
    for (int k = 0; k < 8; k++) if (m[k]) return k;
    return 0;
  endfunction

  function automatic logic [15:0] exp_vert(input logic [7:0] m);
    int dy  = DY[mv_bit(m)];
    int hdg = (dy > 0) ? 'h00 : 'h7F;
    int mag = (dy < 0) ? -dy : dy;
    return 16'((2 << 12) + (hdg << 4) + mag);
  endfunction

  function automatic logic [15:0] exp_horz(input logic [7:0] m);
    int dx  = DX[mv_bit(m)];
    int hdg = (dx > 0) ? 'hBF : 'h3F;
    int mag = (dx < 0) ? -dx : dx;
    return 16'((3 << 12) + (hdg << 4) + mag);
  endfunction

  function automatic logic [7:0] rand_move();
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (c_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    if (use6) start6 = 1'b1;
    else      start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    start6 = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic host_abort();
    cmd_UART = 16'hF000;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  // Acknowledge both legs of one move, returning the two observed commands
  task automatic run_move(output logic [15:0] vc, output logic [15:0] hc, output bit ok);
    bit ok1, ok2;
    wait_rdy(ok1);
    vc = c_cmd;
    pulse_clr();
    idle_cycles($urandom_range(0, 3));
    pulse_send();
    wait_rdy(ok2);
    hc = c_cmd;
    pulse_clr();
    idle_cycles($urandom_range(0, 3));
    pulse_send();
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rdy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cmd_rdy: got %b expected 0", rdy5); end
    n_checks++; if (cmd5 !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_cmd: got %h expected 0000", cmd5); end
    n_checks++; if (resp5 !== 8'h5A) begin n_fail++; $display("[TB] FAIL reset_resp: got %h expected 5a", resp5); end
    n_checks++; if ({busy5, paused5, busy6, paused6} !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy5, paused5, busy6, paused6}); end
    n_checks++; if (idx5 !== 5'd0 || idx6 !== 6'd0) begin n_fail++; $display("[TB] FAIL reset_mv_indx: got %0d/%0d expected 0/0", idx5, idx6); end
  endtask

  task automatic test_pass_through();
    for (int i = 0; i < 8; i++) begin
      cmd_UART     = (i == 0) ? 16'h2002 : 16'($urandom);
      cmd_rdy_UART = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      n_checks++; if (cmd5 !== cmd_UART || rdy5 !== cmd_rdy_UART) begin n_fail++; $display("[TB] FAIL pass_through: got %h/%b expected %h/%b", cmd5, rdy5, cmd_UART, cmd_rdy_UART); end
      @(negedge clk);
    end
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_move();
    use6 = 1'b0;
    sol5[0] = 8'h01;
    sol5[1] = 8'h80;
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    n_checks++; if (rdy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL latency_early: got cmd_rdy %b expected 0", rdy5); end
    @(negedge clk);
    n_checks++; if (rdy5 !== 1'b1 || cmd5 !== 16'h2002) begin n_fail++; $display("[TB] FAIL single_vert: got %h/%b expected 2002/1", cmd5, rdy5); end
    pulse_clr();
    n_checks++; if (rdy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL single_clr: got cmd_rdy %b expected 0", rdy5); end
    pulse_send();
    n_checks++; if (rdy5 !== 1'b1 || cmd5 !== 16'h3BF1) begin n_fail++; $display("[TB] FAIL single_horz: got %h/%b expected 3bf1/1", cmd5, rdy5); end
    pulse_clr();
    pulse_send();
    n_checks++; if (resp5 !== 8'h5A || idx5 !== 5'd1) begin n_fail++; $display("[TB] FAIL single_done: got resp %h idx %0d expected 5a idx 1", resp5, idx5); end
    @(negedge clk);
    n_checks++; if (rdy5 !== 1'b1 || cmd5 !== exp_vert(sol5[1])) begin n_fail++; $display("[TB] FAIL second_vert: got %h/%b expected %h/1", cmd5, rdy5, exp_vert(sol5[1])); end
    cmd_UART = 16'hF000;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    n_checks++; if (rdy5 !== 1'b0 || idx5 !== 5'd0 || resp5 !== 8'hEE) begin n_fail++; $display("[TB] FAIL abort_opcode: got rdy %b idx %0d resp %h expected 0 0 ee", rdy5, idx5, resp5); end
    @(negedge clk);
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle: got busy %b expected 0", busy5); end
  endtask

  task automatic test_illegal_move();
    use6 = 1'b0;
    force_en = 1'b1;
    force_mv = 8'h03;
    pulse_start();
    @(negedge clk);
    n_checks++; if (resp5 !== 8'hEE || rdy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL illegal_resp: got %h/%b expected ee/0", resp5, rdy5); end
    @(negedge clk);
    n_checks++; if (busy5 !== 1'b0 || idx5 !== 5'd0) begin n_fail++; $display("[TB] FAIL illegal_idle: got busy %b idx %0d expected 0 0", busy5, idx5); end
    force_en = 1'b0;
  endtask

  task automatic test_full_tour(input bit six);
    int n, cmds, max_idx;
    logic [15:0] vc, hc;
    logic [7:0] m;
    bit ok;
    use6 = six;
    n = six ? 35 : 24;
    for (int i = 0; i < 64; i++) begin
      if (i < 32) sol5[i] = rand_move();
      sol6[i] = rand_move();
    end
    cmds = 0;
    max_idx = 0;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      m = six ? sol6[i] : sol5[i];
      run_move(vc, hc, ok);
      if (ok) cmds += 2;
      n_checks++; if (vc !== exp_vert(m) || hc !== exp_horz(m)) begin n_fail++; $display("[TB] FAIL tour%0d_move%0d: got %h %h expected %h %h", n + 1, i, vc, hc, exp_vert(m), exp_horz(m)); end
      if (int'(c_idx) > max_idx) max_idx = int'(c_idx);
      if (i < n - 1) begin
        n_checks++; if (c_resp !== 8'h5A || c_idx !== 6'(i + 1)) begin n_fail++; $display("[TB] FAIL tour%0d_step%0d: got resp %h idx %0d expected 5a idx %0d", n + 1, i, c_resp, c_idx, i + 1); end
      end else begin
        n_checks++; if (c_resp !== 8'hA5) begin n_fail++; $display("[TB] FAIL tour%0d_end_resp: got %h expected a5", n + 1, c_resp); end
      end
    end
    @(negedge clk);
    n_checks++; if (c_busy !== 1'b0 || c_resp !== 8'hA5) begin n_fail++; $display("[TB] FAIL tour%0d_idle: got busy %b resp %h expected 0 a5", n + 1, c_busy, c_resp); end
    n_checks++; if (cmds !== 2 * n || max_idx !== n - 1) begin n_fail++; $display("[TB] FAIL tour%0d_count: got %0d cmds max idx %0d expected %0d cmds max idx %0d", n + 1, cmds, max_idx, 2 * n, n - 1); end
    use6 = 1'b0;
  endtask

  task automatic test_pause_resume();
    logic [15:0] vc, hc;
    bit ok;
    use6 = 1'b0;
    for (int i = 0; i < 32; i++) sol5[i] = rand_move();
    pulse_start();
    for (int i = 0; i < 3; i++) run_move(vc, hc, ok);
    wait_rdy(ok);
    n_checks++; if (!ok || cmd5 !== exp_vert(sol5[3]) || idx5 !== 5'd3) begin n_fail++; $display("[TB] FAIL pause_move3_vert: got %h idx %0d expected %h idx 3", cmd5, idx5, exp_vert(sol5[3])); end
    pulse_start();
    n_checks++; if (rdy5 !== 1'b1 || idx5 !== 5'd3 || cmd5 !== exp_vert(sol5[3])) begin n_fail++; $display("[TB] FAIL busy_start_ignored: got %h/%b idx %0d expected %h/1 idx 3", cmd5, rdy5, idx5, exp_vert(sol5[3])); end
    cmd_UART = 16'h0ABC;
    cmd_rdy_UART = 1'b1;
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0;
    n_checks++; if (paused5 !== 1'b0) begin n_fail++; $display("[TB] FAIL pause_early: got paused %b expected 0", paused5); end
    pulse_send();
    n_checks++; if (paused5 !== 1'b1 || idx5 !== 5'd3 || busy5 !== 1'b1) begin n_fail++; $display("[TB] FAIL paused_state: got paused %b idx %0d busy %b expected 1 3 1", paused5, idx5, busy5); end
    cmd_UART = 16'h4321;
    cmd_rdy_UART = 1'b1;
    #1;
    n_checks++; if (cmd5 !== 16'h4321 || rdy5 !== 1'b1) begin n_fail++; $display("[TB] FAIL paused_pass_through: got %h/%b expected 4321/1", cmd5, rdy5); end
    @(negedge clk);
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
    pulse_start();
    n_checks++; if (rdy5 !== 1'b1 || cmd5 !== exp_horz(sol5[3])) begin n_fail++; $display("[TB] FAIL resume_horz: got %h/%b expected %h/1", cmd5, rdy5, exp_horz(sol5[3])); end
    pulse_clr();
    cmd_rdy_UART = 1'b1;
    send_resp = 1'b1;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    send_resp = 1'b0;
    n_checks++; if (paused5 !== 1'b1 || idx5 !== 5'd4 || resp5 !== 8'h5A) begin n_fail++; $display("[TB] FAIL pause_with_resp: got paused %b idx %0d resp %h expected 1 4 5a", paused5, idx5, resp5); end
    pulse_start();
    wait_rdy(ok);
    n_checks++; if (!ok || cmd5 !== exp_vert(sol5[4])) begin n_fail++; $display("[TB] FAIL resume_load: got %h expected %h", cmd5, exp_vert(sol5[4])); end
    host_abort();
    n_checks++; if (busy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL pause_abort_idle: got busy %b expected 0", busy5); end
  endtask

  task automatic test_reset_mid_tour();
    logic [15:0] vc, hc;
    bit ok;
    use6 = 1'b0;
    for (int i = 0; i < 32; i++) sol5[i] = rand_move();
    pulse_start();
    run_move(vc, hc, ok);
    wait_rdy(ok);
    pulse_clr();
    pulse_send();
    wait_rdy(ok);
    pulse_clr();
    n_checks++; if (busy5 !== 1'b1 || idx5 !== 5'd1 || rdy5 !== 1'b0) begin n_fail++; $display("[TB] FAIL pre_reset_wait_h: got busy %b idx %0d rdy %b expected 1 1 0", busy5, idx5, rdy5); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({busy5, paused5, rdy5} !== 3'b000 || idx5 !== 5'd0 || resp5 !== 8'h5A || cmd5 !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset: got busy %b paused %b rdy %b idx %0d resp %h cmd %h expected 0 0 0 0 5a 0000", busy5, paused5, rdy5, idx5, resp5, cmd5); end
    cmd_UART = 16'h1234;
    cmd_rdy_UART = 1'b1;
    #1;
    n_checks++; if (cmd5 !== 16'h1234 || rdy5 !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_pass_through: got %h/%b expected 1234/1", cmd5, rdy5); end
    @(negedge clk);
    cmd_UART = 16'h0000;
    cmd_rdy_UART = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    rst = 1'b1; start5 = 1'b0; start6 = 1'b0; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; cmd_UART = 16'h0000;
    force_en = 1'b0; force_mv = 8'h00; use6 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < 32) sol5[i] = 8'h01;
      sol6[i] = 8'h01;
    end
    @(negedge clk);
    test_reset();
    test_pass_through();
    test_single_move();
    test_illegal_move();
    test_full_tour(1'b0);
    test_full_tour(1'b1);
    test_pause_resume();
    test_reset_mid_tour();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_move_sequencer.md
Name: tour_move_sequencer

Overview:
Parametrised tour command sequencer sitting between the UART command path, the tour solver and the command processor in the knight top level. In pass-through mode it forwards host commands unchanged. In tour mode it walks the solver's move list, splits each knight move into a vertical leg and a horizontal leg, and issues each leg to the command processor. It returns 0x5A per completed move and 0xA5 at tour end. New over the fixed 5x5 version: board dimension is a parameter, and a tour can be paused, resumed mid-list and aborted.

Parameters:
BOARD_DIM, 5, board side in squares (legal 3..8); move count NUM_MV = BOARD_DIM*BOARD_DIM-1
CMD_W, 16, command word width
IDX_W, $clog2(BOARD_DIM*BOARD_DIM), width of mv_indx

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start_tour  in  1  pulse; starts the tour, or resumes it when paused
move  in  8  one-hot knight move for mv_indx, from the solver
mv_indx  out  IDX_W  index of the move currently requested
cmd_UART  in  CMD_W  host command
cmd_rdy_UART  in  1  host command valid
clr_cmd_rdy  in  1  command processor has consumed cmd
send_resp  in  1  pulse; command processor finished the current leg
cmd  out  CMD_W  command to the command processor
cmd_rdy  out  1  cmd valid
resp  out  8  response byte
tour_busy  out  1  high in any state other than IDLE
paused  out  1  high in PAUSED

Behaviour:
- Reset: state IDLE, mv_indx=0, cmd_rdy=0, cmd=0, resp=8'h5A, tour_busy=0, paused=0.
- IDLE (pass-through), combinational: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART.
- IDLE + start_tour -> LOAD, mv_indx=0.
- LOAD: latch move and decode dx, dy (signed, 3 bits each).
  - Encoding bit0..7 = (+1,+2), (-1,+2), (-2,+1), (-2,-1), (-1,-2), (+1,-2), (+2,-1), (+2,+1).
  - move not exactly one-hot -> ABORT.
- VERT: cmd = {4'b0010, heading, |dy|}, heading NORTH if dy>0, else SOUTH. Assert cmd_rdy.
- Hold cmd/cmd_rdy until clr_cmd_rdy, then drop cmd_rdy next cycle -> WAIT_V.
- WAIT_V + send_resp -> HORZ.
- HORZ: cmd = {4'b0011, heading, |dx|} (0011 = move with fanfare), heading EAST if dx>0, else WEST. Same handshake -> WAIT_H.
- WAIT_H + send_resp:
  - mv_indx==NUM_MV-1 -> resp=8'hA5 -> DONE.
  - Otherwise resp=8'h5A, mv_indx+1 -> LOAD.
- Pause: cmd_rdy_UART with cmd_UART[15:12]==4'b0000 while tour_busy is latched. When the in-flight leg's send_resp arrives, go to PAUSED instead of the next leg. mv_indx and the pending leg are retained.
- PAUSED: start_tour resumes at the pending leg (HORZ if the vertical leg was done, else LOAD). Other UART commands pass through as in IDLE.
- Abort: cmd_UART[15:12]==4'b1111 in any non-IDLE state -> ABORT. ABORT drops cmd_rdy, sets resp=8'hEE, returns to IDLE next cycle, mv_indx=0.
- DONE -> IDLE after one cycle; resp holds 8'hA5 until the next start_tour.
- Handshake and ignore rules:
  - clr_cmd_rdy outside VERT/HORZ is ignored.
  - send_resp outside WAIT_* is ignored.
  - start_tour while busy and not paused is ignored.
- Simultaneous pause request and send_resp in the same cycle: the pause wins, and the leg counts as complete.
- rst mid-tour forces the reset values regardless of state.
- Heading constants: NORTH=8'h00, WEST=8'h3F, SOUTH=8'h7F, EAST=8'hBF.
- Latency: start_tour to first cmd_rdy = 2 clk.

Decomposition:
- Package tour_pkg holds: state enum, heading constants, opcode constants (MOVE=4'b0010, MOVE_FF=4'b0011, PAUSE=4'b0000, ABORT=4'b1111), response constants (RESP_MV=8'h5A, RESP_DONE=8'hA5, RESP_ABT=8'hEE).
- One sub-module, knight_move_decode: combinational, one-hot move -> dx, dy, valid.

Test Plan:
- Pass-through: in IDLE, cmd_UART=16'h2002 with cmd_rdy_UART=1 -> cmd=16'h2002, cmd_rdy=1 in the same cycle.
- Single move: start_tour, move=8'h01 -> cmd=16'h2002 (north 2). After clr_cmd_rdy and send_resp -> cmd=16'h3BF1 (east 1). After send_resp -> resp=8'h5A, mv_indx=1.
- Full tour, BOARD_DIM=5: model the solver with a 24-entry list and ack every leg. Require 48 commands, mv_indx reaching 23, resp=8'hA5, tour_busy=0 afterwards. Repeat with BOARD_DIM=6: 35 moves.
- Pause/resume: pause during the vertical leg of move 3 -> paused=1 after that leg's send_resp, mv_indx=3. start_tour -> next cmd is the horizontal leg of move 3.
- Abort/illegal: move=8'h03 -> resp=8'hEE and IDLE within 2 clk. Separately, opcode 4'b1111 mid-leg -> cmd_rdy=0, mv_indx=0.
- Reset mid-tour: assert rst during WAIT_H -> next cycle all outputs at reset values, pass-through restored.
